// File: rtl/meter_key_pkg.sv
// Shared constants for the parking-meter key conditioner: key bit mapping and
// default timing. Optional auto-repeat is enabled with the KEY_AUTOREPEAT_EN macro.
package meter_key_pkg;

  localparam int NUM_KEYS = 6;

  localparam int KEY_ADD1 = 0;
  localparam int KEY_ADD2 = 1;
  localparam int KEY_ADD3 = 2;
  localparam int KEY_ADD4 = 3;
  localparam int KEY_RST2 = 4;
  localparam int KEY_RST1 = 5;

  // 100 Hz clock: 3 cycles = 30 ms debounce, 1 s repeat delay, 250 ms repeat period
  localparam int DEBOUNCE_CYCLES_DEF = 3;
  localparam int REPEAT_DELAY_DEF    = 100;
  localparam int REPEAT_PERIOD_DEF   = 25;

endpackage

// File: rtl/meter_key_conditioner_key_debounce.sv
// One key: 2-flop synchronizer, debounce counter and accepted stable level.
// press_evt is high in the cycle whose closing edge flips stable from 0 to 1.
module key_debounce
  import meter_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic stable,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept    = (sync2 != stable) && (cnt == CNT_LAST);
  assign press_evt = accept && sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Any return to the accepted level restarts the count, rejecting glitches
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/meter_key_conditioner.sv
// Debounces six meter pushbuttons and issues at most one key pulse per cycle,
// queuing simultaneous presses in priority order. Macro: KEY_AUTOREPEAT_EN.
module meter_key_conditioner
  import meter_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                pend_any
);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press_evt;
  logic [NUM_KEYS-1:0] rep_evt;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] issue;
  logic [NUM_KEYS-1:0] pending_nxt;

  // Highest set bit wins: rst1 > rst2 > add4 > add3 > add2 > add1
  function automatic logic [NUM_KEYS-1:0] pri_onehot(input logic [NUM_KEYS-1:0] req);
    pri_onehot = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (req[i]) pri_onehot = NUM_KEYS'(1) << i;
    end
  endfunction

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .key_raw  (key_raw[i]),
      .stable   (stable[i]),
      .press_evt(press_evt[i])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_WRAP  = HW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_BASE  = HW'(REPEAT_DELAY);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_repeat
    if (i <= KEY_ADD4) begin : g_add
      logic [HW-1:0] hold_cnt;

      // Fires on the edge where the hold count reaches the delay, then every period
      assign rep_evt[i] = stable[i] && !press_evt[i] &&
                          ((hold_cnt == HOLD_FIRST) || (hold_cnt == HOLD_WRAP));

      always_ff @(posedge clk) begin
        if (rst || !stable[i] || press_evt[i]) begin
          hold_cnt <= '0;
        end else if (hold_cnt == HOLD_WRAP) begin
          hold_cnt <= HOLD_BASE;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end else begin : g_rst_key
      assign rep_evt[i] = 1'b0;
    end
  end
`else
  assign rep_evt = '0;
`endif

  // A new event on the key being issued this edge merges into that pulse
  assign issue       = pri_onehot(pending);
  assign pending_nxt = (pending | press_evt | rep_evt) & ~issue;
  assign key_held    = stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      key_pulse <= '0;
      pend_any  <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      key_pulse <= issue;
      pend_any  <= |pending_nxt;
    end
  end

endmodule

// File: tb/tb_meter_key_conditioner.sv
// Directed and randomized bench for meter_key_conditioner against a behavioural
// key model (run-length debounce, pending set with priority issue).
module tb_meter_key_conditioner;

  localparam int DEB = 3;
  localparam int RD  = 100;
  localparam int RP  = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key_raw;
  logic [5:0] key_pulse;
  logic [5:0] key_held;
  logic       pend_any;

  int checks   = 0;
  int failures = 0;

  meter_key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .key_pulse(key_pulse),
    .key_held (key_held),
    .pend_any (pend_any)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [5:0] m_s1, m_s2, m_st, m_pend, m_pulse;
  int       m_run [6];
  int       m_hold[6];
  bit [5:0] obs_q[$];

  task automatic model_edge(input logic [5:0] r, input logic rs);
    bit [5:0] press, iss, old_st;
    if (rs) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0; m_pulse = '0;
      for (int i = 0; i < 6; i++) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end
      return;
    end
    press  = '0;
    iss    = '0;
    old_st = m_st;
    // A level is accepted after DEB consecutive edges of disagreement
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_st[i]  = m_s2[i];
          m_run[i] = 0;
          press[i] = m_st[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = r;
`ifdef KEY_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) begin
      if (old_st[i] && !press[i]) begin
        m_hold[i]++;
        if (m_hold[i] >= RD && ((m_hold[i] - RD) % RP) == 0) press[i] = 1'b1;
      end else begin
        m_hold[i] = 0;
      end
    end
`endif
    for (int i = 5; i >= 0; i--) begin
      if (m_pend[i]) begin
        iss[i] = 1'b1;
        break;
      end
    end
    m_pulse = iss;
    m_pend  = (m_pend & ~iss) | (press & ~iss);
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [5:0] r, input logic rs);
    key_raw = r;
    rst     = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    chk("key_pulse", key_pulse, m_pulse);
    chk("key_held", key_held, m_st);
    chk("pend_any", {5'b0, pend_any}, {5'b0, |m_pend});
    chk("onehot", {5'b0, $countones(key_pulse) <= 1}, 6'd1);
    if (key_pulse != 6'b0) obs_q.push_back(key_pulse);
  endtask

  task automatic idle(input logic [5:0] r, input int n);
    for (int k = 0; k < n; k++) step(r, 1'b0);
  endtask

  int count_bit;

  initial begin
    key_raw = '0;
    rst     = 1'b1;
    step(6'b0, 1'b1);
    step(6'b0, 1'b1);
    chk("reset_pulse", key_pulse, 6'b0);
    chk("reset_held", key_held, 6'b0);
    idle(6'b0, 4);

    // Single clean press of add1
    obs_q.delete();
    idle(6'b000001, 10);
    chk("add1_npulses", 6'(obs_q.size()), 6'd1);
    if (obs_q.size() > 0) chk("add1_value", obs_q[0], 6'b000001);
    chk("add1_held", key_held, 6'b000001);
    idle(6'b0, 8);

    // Two-cycle glitch on add3 is rejected
    obs_q.delete();
    idle(6'b000100, 2);
    idle(6'b0, 8);
    chk("glitch_npulses", 6'(obs_q.size()), 6'd0);
    chk("glitch_held", key_held, 6'b0);

    // add4 and add1 together: issued add4 first, then add1
    obs_q.delete();
    idle(6'b001001, 10);
    chk("simul_npulses", 6'(obs_q.size()), 6'd2);
    if (obs_q.size() == 2) begin
      chk("simul_first", obs_q[0], 6'b001000);
      chk("simul_second", obs_q[1], 6'b000001);
    end
    chk("simul_pend_any", {5'b0, pend_any}, 6'd0);
    idle(6'b0, 8);

    // Bounce on rst1, then release and press again
    obs_q.delete();
    step(6'b100000, 1'b0); step(6'b000000, 1'b0);
    step(6'b100000, 1'b0); step(6'b000000, 1'b0);
    idle(6'b100000, 12);
    chk("bounce_npulses", 6'(obs_q.size()), 6'd1);
    idle(6'b0, 8);
    idle(6'b100000, 8);
    chk("bounce_npulses2", 6'(obs_q.size()), 6'd2);
    if (obs_q.size() == 2) chk("bounce_value", obs_q[1], 6'b100000);
    idle(6'b0, 8);

    // Reset while add2 press is pending
    obs_q.delete();
    for (int n = 0; n < 12 && m_pend == 6'b0; n++) step(6'b000010, 1'b0);
    chk("pre_rst_pending", {5'b0, pend_any}, 6'd1);
    step(6'b000010, 1'b1);
    chk("rst_held_clear", key_held, 6'b0);
    chk("rst_pend_clear", {5'b0, pend_any}, 6'd0);
    idle(6'b000010, 10);
    chk("rst_npulses", 6'(obs_q.size()), 6'd1);
    if (obs_q.size() > 0) chk("rst_value", obs_q[0], 6'b000010);
    idle(6'b0, 8);

`ifdef KEY_AUTOREPEAT_EN
    obs_q.delete();
    idle(6'b000010, 200);
    chk("repeat_npulses", 6'(obs_q.size()), 6'd5);
    idle(6'b0, 8);
    obs_q.delete();
    idle(6'b010000, 200);
    chk("norepeat_npulses", 6'(obs_q.size()), 6'd1);
    idle(6'b0, 8);
`endif

    // Randomized: slow toggles, glitches and occasional reset
    begin
      logic [5:0] r;
      r = '0;
      for (int k = 0; k < 1500; k++) begin
        for (int i = 0; i < 6; i++) begin
          if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
        end
        step(r, ($urandom_range(0, 199) == 0));
      end
      idle(6'b0, 10);
    end

    count_bit = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
